// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared types and helpers for the SPI requester arbiter.
//   arb_state_e  : burst sequencing FSM states
//   DEF_*        : default parameter values
//   sat_len()    : maps a requested burst length into 1..max_len
package spi_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DW      = 8;
  localparam int DEF_MAX_LEN = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOAD,
    ST_WAIT,
    ST_HOLD
  } arb_state_e;

  // A zero-length request still moves one byte; oversized requests clamp.
  function automatic int unsigned sat_len(input int unsigned len,
                                          input int unsigned max_len);
    if (len == 0)      return 1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker with a registered priority
// pointer.
//   clk_i, rst_i : clock, synchronous active-high reset (pointer -> 0)
//   req          : request vector
//   upd_en       : advance pointer to one past the current pick
//   grant        : one-hot pick (0 if no request)
//   idx          : binary index of the pick
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req,
  input  logic               upd_en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] ptr_q;

  // Scan starting at the pointer and wrapping; first set bit wins.
  always_comb begin
    logic found;
    int   j;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      ptr_q <= '0;
    else if (upd_en)
      ptr_q <= (idx == IDX_W'(NUM_REQ-1)) ? '0 : idx + IDX_W'(1);
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter: shares one SPI master byte engine among NUM_REQ
// requesters. Grants round-robin, holds the owner's chip select for the
// whole burst and sequences start/ready/done per byte.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   req_i, len_i     : per-requester burst request / length (bytes)
//   tx_data_i        : per-requester next byte; tx_ack_o pulses on consume
//   rx_data_o        : last received byte, qualified by one-hot rx_valid_o
//   done_o           : one-hot burst-complete pulse
//   grant_o, busy_o  : current owner / burst in progress
//   ss_n_o           : active-low chip selects
//   spi_*            : SPI master byte engine handshake
// Every output is a flop; the FSM computes next values combinationally.
module spi_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DW      = DEF_DW,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN+1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ-1:0][LEN_W-1:0]  len_i,
  input  logic [NUM_REQ-1:0][DW-1:0]     tx_data_i,
  output logic [NUM_REQ-1:0]             tx_ack_o,
  output logic [DW-1:0]                  rx_data_o,
  output logic [NUM_REQ-1:0]             rx_valid_o,
  output logic [NUM_REQ-1:0]             done_o,
  output logic [NUM_REQ-1:0]             grant_o,
  output logic                           busy_o,
  output logic [NUM_REQ-1:0]             ss_n_o,
  output logic [DW-1:0]                  spi_din_o,
  output logic                           spi_start_o,
  input  logic                           spi_ready_i,
  input  logic                           spi_done_tick_i,
  input  logic [DW-1:0]                  spi_dout_i
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;

  logic [NUM_REQ-1:0] grant_d, ss_n_d, tx_ack_d, rx_valid_d, done_d;
  logic [DW-1:0]      rx_data_d, din_d;
  logic               busy_d, start_d;

  logic [NUM_REQ-1:0] arb_req, arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_upd;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .req    (arb_req),
    .upd_en (arb_upd),
    .grant  (arb_grant),
    .idx    (arb_idx)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    grant_d    = grant_o;
    ss_n_d     = ss_n_o;
    busy_d     = busy_o;
    din_d      = spi_din_o;
    rx_data_d  = rx_data_o;
    start_d    = 1'b0;
    tx_ack_d   = '0;
    rx_valid_d = '0;
    done_d     = '0;
    arb_req    = req_i;
    arb_upd    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          idx_d   = arb_idx;
          len_d   = LEN_W'(sat_len(32'(len_i[arb_idx]), MAX_LEN));
          cnt_d   = '0;
          grant_d = arb_grant;
          ss_n_d  = ~arb_grant;
          busy_d  = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_LOAD;
      ST_LOAD: begin
        if (spi_ready_i) begin
          din_d    = tx_data_i[idx_q];
          start_d  = 1'b1;
          tx_ack_d = grant_o;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (spi_done_tick_i) begin
          rx_data_d  = spi_dout_i;
          rx_valid_d = grant_o;
          cnt_d      = cnt_q + LEN_W'(1);
          state_d    = (cnt_q == len_q - LEN_W'(1)) ? ST_HOLD : ST_LOAD;
        end
      end
      ST_HOLD: begin
        // Feed the owner back into the picker so the pointer lands on
        // owner+1 regardless of what req_i is doing now.
        arb_req = grant_o;
        arb_upd = 1'b1;
        grant_d = '0;
        ss_n_d  = '1;
        busy_d  = 1'b0;
        done_d  = grant_o;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      grant_o     <= '0;
      ss_n_o      <= '1;
      busy_o      <= 1'b0;
      spi_din_o   <= '0;
      spi_start_o <= 1'b0;
      tx_ack_o    <= '0;
      rx_data_o   <= '0;
      rx_valid_o  <= '0;
      done_o      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      grant_o     <= grant_d;
      ss_n_o      <= ss_n_d;
      busy_o      <= busy_d;
      spi_din_o   <= din_d;
      spi_start_o <= start_d;
      tx_ack_o    <= tx_ack_d;
      rx_data_o   <= rx_data_d;
      rx_valid_o  <= rx_valid_d;
      done_o      <= done_d;
    end
  end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Testbench for spi_req_arbiter: SPI master model echoes din^0x99 a few
// cycles after start; a scoreboard holds expected bytes, rx data, burst
// lengths and grant order pushed when each burst is set up.
module tb_spi_req_arbiter;

  localparam int NR = 4, DW = 8, ML = 8, LW = 4;

  logic                clk, rst;
  logic [NR-1:0]       req_i;
  logic [NR-1:0][LW-1:0] len_i;
  logic [NR-1:0][DW-1:0] tx_data_i;
  logic [NR-1:0]       tx_ack_o, rx_valid_o, done_o, grant_o, ss_n_o;
  logic [DW-1:0]       rx_data_o, spi_din_o, spi_dout_i;
  logic                busy_o, spi_start_o, spi_ready_i, spi_done_tick_i;

  spi_req_arbiter #(.NUM_REQ(NR), .DW(DW), .MAX_LEN(ML), .LEN_W(LW)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req_i), .len_i(len_i),
    .tx_data_i(tx_data_i), .tx_ack_o(tx_ack_o), .rx_data_o(rx_data_o),
    .rx_valid_o(rx_valid_o), .done_o(done_o), .grant_o(grant_o),
    .busy_o(busy_o), .ss_n_o(ss_n_o), .spi_din_o(spi_din_o),
    .spi_start_o(spi_start_o), .spi_ready_i(spi_ready_i),
    .spi_done_tick_i(spi_done_tick_i), .spi_dout_i(spi_dout_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // ---- scoreboard ----
  logic [11:0] exp_tx[$];    // {ack one-hot, byte}
  logic [11:0] exp_rx[$];    // {rx_valid one-hot, byte}
  logic [11:0] exp_done[$];  // {done one-hot, byte count}
  logic [3:0]  exp_grant[$];

  logic [7:0] tx_mem [NR][64];
  int wr_ptr [NR] = '{0, 0, 0, 0};
  int tx_ptr [NR] = '{0, 0, 0, 0};

  always_comb
    for (int i = 0; i < NR; i++) tx_data_i[i] = tx_mem[i][tx_ptr[i]];

  // ---- SPI master model ----
  logic       mbusy, mdone, stall, stray, rdy_seen;
  logic [7:0] mdin, mdout;
  int         mcnt;

  assign spi_ready_i     = !mbusy && !stall;
  assign spi_done_tick_i = mdone | stray;
  assign spi_dout_i      = mdout;

  always @(posedge clk) begin
    rdy_seen <= spi_ready_i;
    if (rst) begin
      mbusy <= 1'b0; mdone <= 1'b0; mcnt <= 0; mdin <= '0; mdout <= '0;
    end else begin
      mdone <= 1'b0;
      if (mbusy) begin
        if (mcnt == 0) begin
          mbusy <= 1'b0; mdone <= 1'b1; mdout <= mdin ^ 8'h99;
        end else mcnt <= mcnt - 1;
      end else if (spi_start_o) begin
        mbusy <= 1'b1; mdin <= spi_din_o; mcnt <= 3;
      end
    end
  end

  // ---- output monitor ----
  int         start_cnt = 0, grant_cnt = 0, rx_in_burst = 0;
  logic [3:0] prev_grant = '0;

  always @(negedge clk) begin
    logic [11:0] e;
    logic [3:0]  g;
    if (rst) begin
      rx_in_burst = 0;
      prev_grant  = '0;
    end else begin
      if (spi_start_o) begin
        start_cnt++;
        chk("start_when_ready", rdy_seen, 1);
        if (exp_tx.size() == 0) chk("tx_extra", {tx_ack_o, spi_din_o}, 0);
        else begin e = exp_tx.pop_front(); chk("tx_byte", {tx_ack_o, spi_din_o}, e); end
      end else chk("ack_wo_start", tx_ack_o, 0);
      for (int i = 0; i < NR; i++) if (tx_ack_o[i]) tx_ptr[i] = (tx_ptr[i] + 1) % 64;

      if (rx_valid_o != 0) begin
        rx_in_burst++;
        if (exp_rx.size() == 0) chk("rx_extra", {rx_valid_o, rx_data_o}, 0);
        else begin e = exp_rx.pop_front(); chk("rx_byte", {rx_valid_o, rx_data_o}, e); end
      end

      if (done_o != 0) begin
        if (exp_done.size() == 0) chk("done_extra", done_o, 0);
        else begin e = exp_done.pop_front(); chk("done_len", {done_o, 8'(rx_in_burst)}, e); end
        chk("done_ssn_high", ss_n_o, 4'hF);
        rx_in_burst = 0;
      end

      if (grant_o != 0 && prev_grant == 0) begin
        grant_cnt++;
        if (exp_grant.size() == 0) chk("grant_extra", grant_o, 0);
        else begin g = exp_grant.pop_front(); chk("grant_order", grant_o, g); end
      end
      if (grant_o != 0 && prev_grant != 0) chk("grant_stable", grant_o, prev_grant);

      if (busy_o || grant_o != 0) begin
        chk("ss_vs_grant", {busy_o, ss_n_o}, {1'b1, ~grant_o});
        chk("grant_onehot", $countones(grant_o), 1);
      end else chk("idle_outs", {ss_n_o, grant_o}, {4'hF, 4'h0});
      prev_grant = grant_o;
    end
  end

  // ---- stimulus helpers ----
  task automatic sb_load(input int idx, input int n, input logic [7:0] base, input logic [7:0] step);
    logic [7:0] b;
    logic [3:0] oh;
    oh = 4'(1 << idx);
    for (int k = 0; k < n; k++) begin
      b = base + 8'(k) * step;
      tx_mem[idx][wr_ptr[idx]] = b;
      wr_ptr[idx] = (wr_ptr[idx] + 1) % 64;
      exp_tx.push_back({oh, b});
      exp_rx.push_back({oh, b ^ 8'h99});
    end
    exp_done.push_back({oh, 8'(n)});
    exp_grant.push_back(oh);
  endtask

  task automatic start_req(input logic [3:0] mask, input int idx, input logic [3:0] len);
    int t;
    @(negedge clk);
    len_i[idx] = len;
    req_i = mask;
    t = 0;
    while (!busy_o && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) chk("timeout_grant", busy_o, 1);
    req_i = '0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy_o && t < 500) begin @(negedge clk); t++; end
    if (t >= 500) chk("timeout_idle", busy_o, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int t, s0;
    rst = 1'b1; req_i = '0; len_i = '0; stall = 1'b0; stray = 1'b0;
    for (int i = 0; i < NR; i++) for (int k = 0; k < 64; k++) tx_mem[i][k] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ss_n", ss_n_o, 4'hF);
    chk("rst_outs", {grant_o, busy_o, spi_start_o, tx_ack_o, rx_valid_o, done_o}, 0);
    chk("rst_data", {rx_data_o, spi_din_o}, 0);
    @(negedge clk); rst = 1'b0;

    // Round robin: all four held high, all len 1 -> order 0,1,2,3,0.
    sb_load(0, 1, 8'h01, 0); sb_load(1, 1, 8'h02, 0); sb_load(2, 1, 8'h03, 0);
    sb_load(3, 1, 8'h04, 0); sb_load(0, 1, 8'h05, 0);
    @(negedge clk);
    len_i = {4'd1, 4'd1, 4'd1, 4'd1};
    req_i = 4'hF;
    s0 = grant_cnt; t = 0;
    while (grant_cnt < s0 + 5 && t < 500) begin @(negedge clk); t++; end
    if (t >= 500) chk("timeout_rr", grant_cnt, s0 + 5);
    req_i = '0;
    wait_idle();

    // Single byte: 0xA5 out, model returns 0x3C.
    sb_load(0, 1, 8'hA5, 0);
    start_req(4'b0001, 0, 4'd1);
    chk("single_ss_n", ss_n_o, 4'b1110);
    wait_idle();

    // Three-byte burst.
    sb_load(0, 3, 8'h11, 8'h11);
    start_req(4'b0001, 0, 4'd3);
    wait_idle();

    // Length boundaries: 0 -> 1 byte, 15 -> MAX_LEN bytes.
    sb_load(2, 1, 8'hC7, 0);
    start_req(4'b0100, 2, 4'd0);
    wait_idle();
    sb_load(3, ML, 8'h40, 8'h01);
    start_req(4'b1000, 3, 4'd15);
    wait_idle();

    // Stray done tick while idle is ignored.
    @(negedge clk); stray = 1'b1;
    @(negedge clk); stray = 1'b0;
    chk("stray_rx", rx_valid_o, 0);
    chk("stray_busy", busy_o, 0);

    // Ready held low in LOAD: no start until ready returns.
    stall = 1'b1;
    sb_load(1, 1, 8'h5A, 0);
    start_req(4'b0010, 1, 4'd1);
    s0 = start_cnt;
    repeat (10) @(negedge clk);
    chk("no_start_stalled", start_cnt - s0, 0);
    stall = 1'b0;
    @(posedge clk); #1;
    chk("start_after_ready", spi_start_o, 1);
    wait_idle();

    // Reset after the second start of a 4-byte burst.
    sb_load(0, 4, 8'h80, 8'h01);
    start_req(4'b0001, 0, 4'd4);
    s0 = start_cnt; t = 0;
    while (start_cnt < s0 + 2 && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) chk("timeout_2nd_start", start_cnt, s0 + 2);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ss_n", ss_n_o, 4'hF);
    chk("midrst_outs", {grant_o, busy_o, done_o, spi_start_o, rx_valid_o}, 0);
    exp_tx.delete(); exp_rx.delete(); exp_done.delete(); exp_grant.delete();
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_no_done", done_o, 0);
    // Requesters 1 and 2 both asking: pointer back at 0 means 1 wins.
    sb_load(1, 2, 8'hE1, 8'h10);
    start_req(4'b0110, 1, 4'd2);
    wait_idle();

    chk("sb_drained", exp_tx.size() + exp_rx.size() + exp_done.size() + exp_grant.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_req_arbiter.md
Name: spi_req_arbiter

Overview:
- Shares one SPI master byte engine between NUM_REQ requesters.
- Each requester asks for a burst of 1..MAX_LEN bytes. The block arbitrates round-robin and drives that requester's chip select for the whole burst.
- It sequences the master's start/ready/done handshake per byte and returns received bytes and a completion pulse to the owner.
- It sits between the requester clients and the SPI master core, on the master's din/start/dout/done/ready ports.

Parameters:
- NUM_REQ, 4, number of requesters and chip selects (2..8).
- DW, 8, SPI byte width; must match the SPI master.
- MAX_LEN, 8, maximum burst length in bytes.
- LEN_W, $clog2(MAX_LEN+1), width of each length field.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  NUM_REQ  per-requester burst request; level, sampled only in IDLE.
- len_i  in  NUM_REQ*LEN_W  per-requester burst length in bytes; sampled at grant.
- tx_data_i  in  NUM_REQ*DW  per-requester next byte to transmit.
- tx_ack_o  out  NUM_REQ  one-hot pulse; the owner's tx_data_i byte was consumed this cycle.
- rx_data_o  out  DW  last received byte.
- rx_valid_o  out  NUM_REQ  one-hot pulse; rx_data_o is valid for that requester.
- done_o  out  NUM_REQ  one-hot pulse; the burst has finished.
- grant_o  out  NUM_REQ  one-hot current owner; 0 when idle.
- busy_o  out  1  a burst is in progress.
- ss_n_o  out  NUM_REQ  active-low chip selects.
- spi_din_o  out  DW  byte to the SPI master.
- spi_start_o  out  1  start pulse to the SPI master.
- spi_ready_i  in  1  SPI master idle.
- spi_done_tick_i  in  1  SPI master byte complete.
- spi_dout_i  in  DW  SPI master received byte.

Behaviour:
- The interface has one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values:
  - ss_n_o all ones.
  - All other outputs 0.
  - State IDLE; RR pointer 0 (requester 0 has highest priority).
- All outputs are registered.
- FSM states: IDLE, SETUP, LOAD, WAIT, HOLD.
- IDLE:
  - If req_i != 0, pick the first set bit at or after the RR pointer, wrapping around. Call it g.
  - Latch g and len_i[g]. A length of 0 is treated as 1; lengths above MAX_LEN saturate to MAX_LEN.
  - Clear the byte counter. Next cycle: grant_o[g]=1, ss_n_o[g]=0, busy_o=1, go to SETUP.
- SETUP: one cycle of CS setup, then go to LOAD.
- LOAD:
  - Wait while spi_ready_i=0.
  - When spi_ready_i=1: spi_din_o<=tx_data_i[g], and spi_start_o and tx_ack_o[g] are high for exactly the next cycle. Go to WAIT.
- WAIT:
  - On spi_done_tick_i: next cycle rx_data_o<=spi_dout_i and rx_valid_o[g]=1; counter increments.
  - If this was the last byte (counter==len-1), go to HOLD; otherwise go to LOAD.
  - ss_n_o[g] stays low continuously between bytes.
- HOLD:
  - One cycle of CS hold.
  - Next cycle: ss_n_o all ones, grant_o=0, busy_o=0, done_o[g] pulses.
  - RR pointer becomes (g+1) mod NUM_REQ; return to IDLE.
- Latency: with spi_ready_i=1, the first spi_start_o is high 3 cycles after the edge that samples req_i in IDLE.
- Exactly one spi_start_o per byte, and never while spi_ready_i=0 or in WAIT.
- req_i changes during a burst are ignored; the burst always completes, and a dropped request is not aborted.
- A spi_done_tick_i outside WAIT is ignored.
- IDLE back-to-back: a new grant can be made in the same cycle done_o is pulsing, so the minimum CS-high gap is 1 cycle.
- Reset mid-burst: on the next edge all outputs return to reset values, including ss_n_o all ones. No done_o is issued and the RR pointer resets to 0. The SPI master shares rst_i.

Decomposition:
- Package spi_arb_pkg holds:
  - state enum type arb_state_e.
  - default parameter constants.
  - function sat_len (0 becomes 1, clamp to MAX_LEN).
- Sub-module rr_arbiter: combinational round-robin picker plus registered pointer. Inputs are req and an update enable; outputs are one-hot grant and index.
- Top-level spi_req_arbiter holds the FSM, counter and muxes.

Test Plan:
- Single byte: req_i=0001, len 1, tx 0xA5; the SPI model returns 0x3C. Required: ss_n_o=1110 during the burst, one spi_start_o with spi_din_o=0xA5, rx_valid_o=0001 with rx_data_o=0x3C, one done_o=0001 pulse, then ss_n_o=1111.
- Burst: req0, len 3, bytes 0x11/0x22/0x33. Required: exactly 3 starts in order, 3 tx_ack_o pulses, ss_n_o[0] low without gaps from SETUP through HOLD, done_o after the third rx_valid_o.
- Round robin: req_i=1111 held after reset, all len 1. Required grant order 0,1,2,3,0; exactly one grant_o bit set at any time; never two ss_n_o bits low.
- Boundaries: len 0 gives exactly one byte. len 15 with MAX_LEN 8 gives exactly 8 bytes.
- Handshake: hold spi_ready_i=0 for 10 cycles in LOAD. Required: no spi_start_o until ready, and start in the cycle after ready rises. A stray spi_done_tick_i in IDLE changes nothing.
- Reset mid-burst: assert rst_i after the 2nd start of a 4-byte burst. Required: next cycle ss_n_o=1111, busy_o=0, no done_o; after release, req_i=0010 is granted normally.
